// File: rtl/maquina_principal_seq.sv
// Sequencer: steps 0..15 advance on TICK, steps 16..18 wait for ACK with
// a per-step timeout; step 19 is a one-cycle FINISH that pulses DONE.
module maquina_principal_seq #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic       TICK,
   input  logic       ACK,
   input  logic       ABORT,
   output logic [4:0] STEP,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR
);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      WAIT_ACK,
      FINISH
   } state_t;

   localparam logic [4:0] STEP_LAST_TICK = 5'd15;
   localparam logic [4:0] STEP_FIRST_ACK = 5'd16;
   localparam logic [4:0] STEP_LAST_ACK  = 5'd18;
   localparam logic [4:0] STEP_FINISH    = 5'd19;
   // The expiring edge is the TIMEOUT-th ACK-low edge, i.e. count already at TIMEOUT-1.
   localparam logic [7:0] TLIMIT         = 8'(TIMEOUT - 1);

   state_t     state;
   state_t     state_n;
   logic [4:0] step_n;
   logic       busy_n;
   logic       done_n;
   logic       err_n;
   logic [7:0] tcnt;
   logic [7:0] tcnt_n;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         STEP  <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         ERR   <= 1'b0;
         tcnt  <= '0;
      end else begin
         state <= state_n;
         STEP  <= step_n;
         BUSY  <= busy_n;
         DONE  <= done_n;
         ERR   <= err_n;
         tcnt  <= tcnt_n;
      end
   end

   always_comb begin
      state_n = state;
      step_n  = STEP;
      busy_n  = BUSY;
      done_n  = 1'b0;
      err_n   = ERR;
      tcnt_n  = tcnt;

      if (ABORT) begin
         state_n = IDLE;
         step_n  = '0;
         busy_n  = 1'b0;
         tcnt_n  = '0;
      end else begin
         case (state)
            IDLE: begin
               step_n = '0;
               busy_n = 1'b0;
               if (START) begin
                  state_n = COUNT;
                  busy_n  = 1'b1;
                  err_n   = 1'b0;
                  tcnt_n  = '0;
               end
            end
            COUNT: begin
               if (TICK) begin
                  step_n = STEP + 5'd1;
                  if (STEP == STEP_LAST_TICK) begin
                     state_n = WAIT_ACK;
                     step_n  = STEP_FIRST_ACK;
                     tcnt_n  = '0;
                  end
               end
            end
            WAIT_ACK: begin
               // ACK wins over a timeout expiring on the same edge.
               if (ACK) begin
                  step_n = STEP + 5'd1;
                  tcnt_n = '0;
                  if (STEP == STEP_LAST_ACK) begin
                     state_n = FINISH;
                     step_n  = STEP_FINISH;
                     done_n  = 1'b1;
                  end
               end else if (tcnt == TLIMIT) begin
                  state_n = IDLE;
                  step_n  = '0;
                  busy_n  = 1'b0;
                  err_n   = 1'b1;
                  tcnt_n  = '0;
               end else begin
                  tcnt_n = tcnt + 8'd1;
               end
            end
            FINISH: begin
               state_n = IDLE;
               step_n  = '0;
               busy_n  = 1'b0;
            end
            default: begin
               state_n = IDLE;
               step_n  = '0;
               busy_n  = 1'b0;
               tcnt_n  = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maquina_principal_seq.sv
// Self-checking bench for maquina_principal_seq: vector table, directed
// corner-case sequences and randomized traffic against a behavioural model.
module tb_maquina_principal_seq;

   localparam int unsigned TMO = 4;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       START = 1'b0;
   logic       TICK = 1'b0;
   logic       ACK = 1'b0;
   logic       ABORT = 1'b0;
   logic [4:0] STEP;
   logic       BUSY;
   logic       DONE;
   logic       ERR;

   maquina_principal_seq #(.TIMEOUT(TMO)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .START (START),
      .TICK  (TICK),
      .ACK   (ACK),
      .ABORT (ABORT),
      .STEP  (STEP),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .ERR   (ERR)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int passes = 0;

   // Behavioural model: sequence phase is implied by step number and busy flag.
   int m_step = 0;
   bit m_busy = 0;
   bit m_done = 0;
   bit m_err  = 0;
   int m_low  = 0;

   function automatic void model_reset();
      m_step = 0; m_busy = 0; m_done = 0; m_err = 0; m_low = 0;
   endfunction

   function automatic void model_edge(input logic s, input logic t, input logic a, input logic ab);
      m_done = 0;
      if (ab) begin
         m_busy = 0; m_step = 0; m_low = 0;
      end else if (!m_busy) begin
         if (s) begin
            m_busy = 1; m_step = 0; m_err = 0; m_low = 0;
         end
      end else if (m_step == 19) begin
         m_busy = 0; m_step = 0;
      end else if (m_step < 16) begin
         if (t) begin
            m_step = m_step + 1;
            m_low = 0;
         end
      end else begin
         if (a) begin
            m_step = m_step + 1;
            m_low = 0;
            if (m_step == 19) m_done = 1;
         end else begin
            m_low = m_low + 1;
            if (m_low == int'(TMO)) begin
               m_err = 1; m_busy = 0; m_step = 0; m_low = 0;
            end
         end
      end
   endfunction

   function automatic logic [7:0] pack_out(input logic [4:0] st, input logic b, input logic d, input logic e);
      return {st, b, d, e};
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got step=%0d busy=%0b done=%0b err=%0b, expected step=%0d busy=%0b done=%0b err=%0b",
                    name, got[7:3], got[2], got[1], got[0], exp[7:3], exp[2], exp[1], exp[0]);
   endtask

   task automatic check_model(input string name);
      check(name, pack_out(STEP, BUSY, DONE, ERR), pack_out(5'(m_step), m_busy, m_done, m_err));
   endtask

   task automatic cyc(input logic s, input logic t, input logic a, input logic ab);
      @(negedge CLK);
      START = s; TICK = t; ACK = a; ABORT = ab;
      @(posedge CLK);
      model_edge(s, t, a, ab);
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      START = 0; TICK = 0; ACK = 0; ABORT = 0;
      RESET = 1;
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      RESET = 0;
   endtask

   typedef struct {
      logic       start;
      logic       tick;
      logic       ack;
      logic       abort;
      logic [4:0] step;
      logic       busy;
      logic       done;
      logic       err;
   } vec_t;

   vec_t vecs[10];
   int   dones;
   int   ticks;
   bit   ack_mode;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};

      do_reset();
      #1;
      check("reset_values", pack_out(STEP, BUSY, DONE, ERR), 8'h00);

      for (int i = 0; i < 10; i++) begin
         cyc(vecs[i].start, vecs[i].tick, vecs[i].ack, vecs[i].abort);
         check($sformatf("vec_%0d", i), pack_out(STEP, BUSY, DONE, ERR),
               pack_out(vecs[i].step, vecs[i].busy, vecs[i].done, vecs[i].err));
      end

      // Full run with TICK and ACK held high.
      dones = 0;
      cyc(1, 1, 1, 0);
      for (int i = 1; i <= 22; i++) begin
         cyc(0, 1, 1, 0);
         if (DONE) dones++;
         check_model($sformatf("full_edge_%0d", i));
         if (i == 16) check("full_step16", pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd16, 1'b1, 1'b0, 1'b0));
         if (i == 19) check("full_finish", pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd19, 1'b1, 1'b1, 1'b0));
         if (i == 20) check("full_idle", pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd0, 1'b0, 1'b0, 1'b0));
      end
      check("full_done_pulses", 8'(dones), 8'd1);

      // Paced run: one TICK every third cycle.
      cyc(1, 0, 0, 0);
      ticks = 0;
      for (int i = 0; i < 60 && ticks < 16; i++) begin
         cyc(0, (i % 3) == 2, 0, 0);
         if ((i % 3) == 2) ticks++;
         check_model($sformatf("paced_%0d", i));
      end
      check("paced_reach16", pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd16, 1'b1, 1'b0, 1'b0));
      cyc(0, 0, 0, 1);
      check_model("paced_abort");

      // Timeout at step 17.
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);
      check("tmo_at17", pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd17, 1'b1, 1'b0, 1'b0));
      for (int i = 1; i <= 3; i++) begin
         cyc(0, 1, 0, 0);
         check($sformatf("tmo_wait_%0d", i), pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd17, 1'b1, 1'b0, 1'b0));
      end
      cyc(0, 1, 0, 0);
      check("tmo_expire", pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd0, 1'b0, 1'b0, 1'b1));
      cyc(0, 0, 0, 1);
      check("tmo_abort_keeps_err", pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd0, 1'b0, 1'b0, 1'b1));
      cyc(1, 0, 0, 0);
      check("tmo_start_clears", pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd0, 1'b1, 1'b0, 1'b0));

      // ACK on the expiring edge wins.
      for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      check("bnd_before", pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd16, 1'b1, 1'b0, 1'b0));
      cyc(0, 0, 1, 0);
      check("bnd_ack_wins", pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd17, 1'b1, 1'b0, 1'b0));
      cyc(1, 1, 1, 1);
      check("abort_at17", pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd0, 1'b0, 1'b0, 1'b0));

      // Asynchronous reset between edges at step 9.
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0);
      check("areset_at9", pack_out(STEP, BUSY, DONE, ERR), pack_out(5'd9, 1'b1, 1'b0, 1'b0));
      @(negedge CLK);
      RESET = 1;
      #1;
      check("areset_immediate", pack_out(STEP, BUSY, DONE, ERR), 8'h00);
      model_reset();
      #1 RESET = 0;
      dones = 0;
      for (int i = 0; i < 25; i++) begin
         cyc(0, 1, 1, 0);
         if (DONE) dones++;
         check_model($sformatf("areset_after_%0d", i));
      end
      check("areset_no_done", 8'(dones), 8'd0);

      // Randomized traffic, alternating ACK-rich and ACK-starved phases.
      ack_mode = 1;
      for (int i = 0; i < 4000; i++) begin
         if ((i % 150) == 0) ack_mode = ~ack_mode;
         cyc($urandom_range(0, 5) == 0,
             $urandom_range(0, 1) == 1,
             ack_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0),
             $urandom_range(0, 99) == 0);
         check_model($sformatf("rand_%0d", i));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
